// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with a 2-entry skid buffer, hold, flush
// and a saturating backpressure counter.
module pipe_stage_skid #(
  parameter int unsigned              DATA_W  = 32,
  parameter logic [DATA_W-1:0]        RST_VAL = {DATA_W{1'b0}},
  parameter int unsigned              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_valid;
  logic                r_ready;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_n;
  logic [DATA_W-1:0]   w_main_n;
  logic [DATA_W-1:0]   w_skid_n;
  logic                w_valid_n;
  logic                w_ready_n;
  logic [CNT_W-1:0]    w_cnt_n;
  logic                w_rdy_eff;
  logic                w_in_fire;
  logic                w_out_fire;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_main  <= w_main_n;
      r_skid  <= w_skid_n;
      r_valid <= w_valid_n;
      r_ready <= w_ready_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next-state, payload routing and stall counter
  always_comb begin
    w_rdy_eff  = ready_i & ~hold_i;
    w_in_fire  = valid_i & r_ready;
    w_out_fire = r_valid & w_rdy_eff;
    w_state_n  = r_state;
    w_main_n   = r_main;
    w_skid_n   = r_skid;
    w_cnt_n    = r_cnt;

    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_n = ST_BUSY;
          w_main_n  = data_i;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_n  = data_i;
        end else if (w_in_fire) begin
          w_state_n = ST_FULL;
          w_skid_n  = data_i;
        end else if (w_out_fire) begin
          w_state_n = ST_EMPTY;
          w_main_n  = RST_VAL;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_n = ST_BUSY;
          w_main_n  = r_skid;
        end
      end
      default: begin
        w_state_n = ST_EMPTY;
        w_main_n  = RST_VAL;
      end
    endcase

    // Flush wins over every handshake in the same cycle
    if (flush_i) begin
      w_state_n = ST_EMPTY;
      w_main_n  = RST_VAL;
    end

    w_valid_n = (w_state_n != ST_EMPTY);
    w_ready_n = (w_state_n != ST_FULL);

    if (cnt_clr_i) begin
      w_cnt_n = '0;
    end else if (r_valid && !w_rdy_eff && (r_cnt != CNT_MAX)) begin
      w_cnt_n = r_cnt + CNT_W'(1);
    end
  end

  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign data_o      = r_main;
  assign stall_cnt_o = r_cnt;

endmodule
